// File: rtl/fdiv_if.sv
// Start/done handshake bundle between the controller and the fp16 divider.
interface fdiv_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fdiv.sv
// Multi-cycle fp16 divider: specials resolved in one cycle, otherwise a 12-cycle
// restoring mantissa divide followed by a truncating pack with flush-to-zero.
module fdiv #(
    parameter logic [15:0] NAN_VALUE = 16'h7E00
) (
    input  logic  clk,
    input  logic  reset,
    fdiv_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UNPACK, DIV, PACK, DONE} state_t;

    state_t             state, state_nx;
    logic [15:0]        a_q, b_q;
    logic [10:0]        mb;
    logic [11:0]        rem, q;
    logic [3:0]         cnt;
    logic signed [6:0]  ed;
    logic               sgn;
    logic [15:0]        res_q;
    logic [3:0]         flg_q;

    logic [4:0]  ea, eb;
    logic [9:0]  fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s;
    logic        spec_hit;
    logic [15:0] spec_res;
    logic [3:0]  spec_flg;
    logic        ge;
    logic [11:0] diff;
    logic signed [7:0] e_pack;
    logic [9:0]  frac;
    logic [15:0] pack_res;
    logic [3:0]  pack_flg;

    always_comb begin
        ea     = a_q[14:10];
        eb     = b_q[14:10];
        fa     = a_q[9:0];
        fb     = b_q[9:0];
        s      = a_q[15] ^ b_q[15];
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        a_inf  = (ea == 5'h1F) && (fa == 10'd0);
        b_inf  = (eb == 5'h1F) && (fb == 10'd0);
        a_nan  = (ea == 5'h1F) && (fa != 10'd0);
        b_nan  = (eb == 5'h1F) && (fb != 10'd0);
    end

    always_comb begin
        spec_hit = 1'b1;
        spec_res = NAN_VALUE;
        spec_flg = 4'b1000;
        if (a_nan || b_nan) begin
            spec_res = NAN_VALUE;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = NAN_VALUE;
        end else if (a_inf) begin
            spec_res = {s, 5'h1F, 10'd0};
            spec_flg = 4'b0000;
        end else if (b_zero) begin
            spec_res = {s, 5'h1F, 10'd0};
            spec_flg = 4'b0100;
        end else if (a_zero || b_inf) begin
            spec_res = {s, 15'd0};
            spec_flg = 4'b0000;
        end else begin
            spec_hit = 1'b0;
            spec_res = '0;
            spec_flg = '0;
        end
    end

    // remainder stays below 2*mb, so the shifted value always fits 12 bits
    always_comb begin
        diff = rem - {1'b0, mb};
        ge   = (rem >= {1'b0, mb});
    end

    always_comb begin
        e_pack   = $signed({ed[6], ed}) + (q[11] ? 8'sd15 : 8'sd14);
        frac     = q[11] ? q[10:1] : q[9:0];
        pack_res = {sgn, e_pack[4:0], frac};
        pack_flg = 4'b0000;
        if (e_pack >= 8'sd31) begin
            pack_res = {sgn, 5'h1F, 10'd0};
            pack_flg = 4'b0010;
        end else if (e_pack <= 8'sd0) begin
            pack_res = {sgn, 15'd0};
            pack_flg = 4'b0001;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = UNPACK;
            UNPACK:  state_nx = spec_hit ? DONE : DIV;
            DIV:     if (cnt == 4'd11) state_nx = PACK;
            PACK:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            mb    <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            ed    <= '0;
            sgn   <= 1'b0;
            res_q <= '0;
            flg_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q <= bus.a;
                    b_q <= bus.b;
                end
                UNPACK: if (spec_hit) begin
                    res_q <= spec_res;
                    flg_q <= spec_flg;
                end else begin
                    rem <= {1'b0, 1'b1, fa};
                    mb  <= {1'b1, fb};
                    ed  <= $signed({2'b00, ea}) - $signed({2'b00, eb});
                    sgn <= s;
                    cnt <= '0;
                    q   <= '0;
                end
                DIV: begin
                    rem <= ge ? {diff[10:0], 1'b0} : {rem[10:0], 1'b0};
                    q   <= {q[10:0], ge};
                    cnt <= cnt + 4'd1;
                end
                PACK: begin
                    res_q <= pack_res;
                    flg_q <= pack_flg;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = res_q;
    assign bus.flags  = flg_q;
endmodule

// File: tb/tb_fdiv.sv
// Scoreboard bench for fdiv: directed cases, random operands, handshake and reset abort.
module tb_fdiv;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [20:0] sb_q[$];   // {special_path, result, flags}

    fdiv_if bus ();

    fdiv #(.NAN_VALUE(16'h7E00)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [20:0] model(input logic [15:0] x, input logic [15:0] y);
        logic s;
        logic [4:0] ex, ey;
        logic [9:0] fx, fy, fr;
        logic zx, zy, ix, iy, nx, ny;
        int q, e;
        s  = x[15] ^ y[15];
        ex = x[14:10]; ey = y[14:10];
        fx = x[9:0];   fy = y[9:0];
        zx = (ex == 0); zy = (ey == 0);
        ix = (ex == 31) && (fx == 0); iy = (ey == 31) && (fy == 0);
        nx = (ex == 31) && (fx != 0); ny = (ey == 31) && (fy != 0);
        if (nx || ny) return {1'b1, 16'h7E00, 4'b1000};
        if ((zx && zy) || (ix && iy)) return {1'b1, 16'h7E00, 4'b1000};
        if (ix) return {1'b1, s, 5'h1F, 10'h0, 4'b0000};
        if (zy) return {1'b1, s, 5'h1F, 10'h0, 4'b0100};
        if (zx || iy) return {1'b1, s, 15'h0, 4'b0000};
        q = ((1024 + int'(fx)) * 2048) / (1024 + int'(fy));
        if (q >= 2048) begin
            fr = 10'((q >> 1) & 1023);
            e  = int'(ex) - int'(ey) + 15;
        end else begin
            fr = 10'(q & 1023);
            e  = int'(ex) - int'(ey) + 14;
        end
        if (e >= 31) return {1'b0, s, 5'h1F, 10'h0, 4'b0010};
        if (e <= 0)  return {1'b0, s, 15'h0, 4'b0001};
        return {1'b0, s, 5'(e), fr, 4'b0000};
    endfunction

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [20:0] exp);
        int k, nbusy, lat;
        logic seen, stable;
        logic [15:0] r0;
        logic [3:0] f0;
        logic [20:0] e;
        sb_q.push_back(exp);
        r0 = bus.result; f0 = bus.flags; stable = 1'b1;
        bus.a = x; bus.b = y; bus.start = 1'b1;
        seen = 1'b0; k = 0; nbusy = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done) seen = 1'b1;
            else if (bus.result !== r0 || bus.flags !== f0) stable = 1'b0;
        end
        e = sb_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL op_timeout a=%h b=%h: no done within %0d cycles", x, y, k);
        end else begin
            lat = e[20] ? 2 : 15;
            total++;
            if (bus.result !== e[19:4]) begin
                bad++;
                $display("FAIL result a=%h b=%h got=%h want=%h", x, y, bus.result, e[19:4]);
            end
            total++;
            if (bus.flags !== e[3:0]) begin
                bad++;
                $display("FAIL flags a=%h b=%h got=%b want=%b", x, y, bus.flags, e[3:0]);
            end
            total++;
            if (k !== lat) begin
                bad++;
                $display("FAIL latency a=%h b=%h got=%0d want=%0d", x, y, k, lat);
            end
            total++;
            if (nbusy !== lat) begin
                bad++;
                $display("FAIL busy_cycles a=%h b=%h got=%0d want=%0d", x, y, nbusy, lat);
            end
            total++;
            if (stable !== 1'b1) begin
                bad++;
                $display("FAIL output_stable a=%h b=%h got=%b want=1", x, y, stable);
            end
        end
        @(negedge clk);
    endtask

    task automatic no_done_window(input string name);
        int extra;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL %s got=%0d extra done pulses want=0", name, extra);
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.result, bus.flags} !== 22'h0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b result=%h flags=%b want all zero",
                     bus.busy, bus.done, bus.result, bus.flags);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        do_op(16'h3C00, 16'h3C00, {1'b0, 16'h3C00, 4'b0000});
        do_op(16'h4600, 16'h4000, {1'b0, 16'h4200, 4'b0000});
        do_op(16'h3C00, 16'h4200, {1'b0, 16'h3555, 4'b0000});
    endtask

    task automatic test_range;
        do_op(16'h7BFF, 16'h1400, {1'b0, 16'h7C00, 4'b0010});
        do_op(16'h0400, 16'h7800, {1'b0, 16'h0000, 4'b0001});
        do_op(16'h8400, 16'h7800, {1'b0, 16'h8000, 4'b0001});
    endtask

    task automatic test_specials;
        do_op(16'hC000, 16'h0000, {1'b1, 16'hFC00, 4'b0100});
        do_op(16'h7E01, 16'h3C00, {1'b1, 16'h7E00, 4'b1000});
        do_op(16'h0000, 16'h8000, {1'b1, 16'h7E00, 4'b1000});
        do_op(16'h7C00, 16'hFC00, {1'b1, 16'h7E00, 4'b1000});
        do_op(16'h3C00, 16'h7C00, {1'b1, 16'h0000, 4'b0000});
    endtask

    task automatic test_random;
        logic [15:0] x, y;
        for (int i = 0; i < 30; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            do_op(x, y, model(x, y));
        end
    endtask

    task automatic test_back_to_back;
        int ndone, since;
        logic [20:0] e;
        sb_q.push_back({1'b0, 16'h4200, 4'b0000});
        sb_q.push_back({1'b0, 16'h3555, 4'b0000});
        bus.a = 16'h4600; bus.b = 16'h4000; bus.start = 1'b1;
        ndone = 0; since = 0;
        for (int k = 0; k < 80 && ndone < 2; k++) begin
            @(negedge clk);
            if (k == 0) begin bus.a = 16'h3C00; bus.b = 16'h4200; end
            if (ndone == 1) begin
                since++;
                if (since == 2) bus.start = 1'b0;
            end
            if (bus.done) begin
                ndone++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    total++;
                    if ({bus.result, bus.flags} !== e[19:0]) begin
                        bad++;
                        $display("FAIL b2b_result got=%h/%b want=%h/%b",
                                 bus.result, bus.flags, e[19:4], e[3:0]);
                    end
                end
            end
        end
        bus.start = 1'b0;
        total++;
        if (ndone !== 2) begin
            bad++;
            $display("FAIL b2b_done_count got=%0d want=2", ndone);
        end
        sb_q.delete();
        @(negedge clk);
        no_done_window("b2b_no_extra_done");
    endtask

    task automatic test_ignore_start;
        int k;
        logic seen, held;
        do_op(16'h4600, 16'h4000, {1'b0, 16'h4200, 4'b0000});
        sb_q.push_back({1'b0, 16'h3555, 4'b0000});
        bus.a = 16'h3C00; bus.b = 16'h4200; bus.start = 1'b1;
        k = 0; seen = 1'b0; held = 1'b1;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            bus.start = (k == 5);
            if (k == 5) begin bus.a = 16'h7BFF; bus.b = 16'h1400; end
            if (bus.done) seen = 1'b1;
            else if (bus.result !== 16'h4200) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL ignore_hold got=%b want=1 (result left 4200 early)", held);
        end
        total++;
        if (!seen || k !== 15) begin
            bad++;
            $display("FAIL ignore_latency got=%0d want=15", k);
        end
        if (sb_q.size() > 0) begin
            total++;
            if ({bus.result, bus.flags} !== sb_q[0][19:0]) begin
                bad++;
                $display("FAIL ignore_result got=%h want=%h", bus.result, sb_q[0][19:4]);
            end
            void'(sb_q.pop_front());
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_done_start got busy=%b want=0", bus.busy);
        end
        no_done_window("ignore_no_extra_done");
    endtask

    task automatic test_reset_midop;
        bus.a = 16'h3C00; bus.b = 16'h3C00; bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.result, bus.flags} !== 22'h0) begin
            bad++;
            $display("FAIL midop_reset got busy=%b done=%b result=%h flags=%b want all zero",
                     bus.busy, bus.done, bus.result, bus.flags);
        end
        @(negedge clk);
        reset = 1'b0;
        no_done_window("midop_no_done");
        do_op(16'h3C00, 16'h3C00, {1'b0, 16'h3C00, 4'b0000});
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_specials();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fdiv.md
Name: fdiv

Overview:
- Multi-cycle IEEE-754 half-precision (fp16) divider: result = a / b.
- Companion to the single-cycle fp16 multiplier in the ALU; long-latency, so it runs as a start/done coprocessor instead of inside the combinational ALU path.
- The controller holds the pipeline while busy is high and captures result/flags on done.

Parameters:
- NAN_VALUE, 16'h7E00, canonical quiet NaN returned for every invalid case.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  16  fp16 dividend.
- b  input  16  fp16 divisor.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  16  fp16 quotient; held until the next completion.
- flags  output  4  {invalid, divzero, overflow, underflow}; updated together with result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=16'h0000, flags=4'b0000. Reset mid-operation aborts immediately; nothing is written afterward.
- States: IDLE, UNPACK, DIV, PACK, DONE.
- IDLE:
  - start=1 at edge E0 latches a and b, then goes to UNPACK.
  - start while busy=1 (including DONE) is ignored and does not queue.
- Operand decode:
  - s=bit15, e=bits14:10, f=bits9:0.
  - e=0 is zero, with flush-to-zero: subnormals are treated as signed zero.
  - e=31, f=0 is inf; e=31, f!=0 is NaN.
- UNPACK (edge E1): special cases are resolved in this precedence, then the block goes straight to DONE:
  1. Any NaN operand -> NAN_VALUE, invalid=1.
  2. 0/0 or inf/inf -> NAN_VALUE, invalid=1.
  3. inf/finite -> signed inf.
  4. nonzero finite/0 -> signed inf, divzero=1.
  5. 0/nonzero, or finite/inf -> signed zero.
  - Sign is sa^sb for all non-NaN results.
  - Otherwise: ma={1,fa}, mb={1,fb}, exponent difference ed = ea - eb (signed, 7 bits), clear the remainder, go to DIV.
- DIV (edges E2..E13, 12 cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - Produces Q = floor((ma<<11)/mb), 12 bits.
  - Q >= 1024 always holds.
- PACK (edge E14):
  - If Q[11]=1: frac=Q[10:1], E=ed+15. Else: frac=Q[9:0], E=ed+14.
  - Rounding is truncation (round toward zero). No guard/sticky bits.
  - E >= 31 -> signed inf (exp 31, frac 0), overflow=1.
  - E <= 0 -> signed zero, underflow=1 (flush-to-zero).
  - Otherwise -> {s, E[4:0], frac}.
  - result and flags are written, then state goes to DONE.
- DONE: done=1 for exactly one cycle, busy still 1. Next edge -> IDLE.
- Latency:
  - Normal path: done is high in the cycle after E14, 14 edges after the start-sampling edge.
  - Special path: result is written at E1, done is high after E1.
  - Earliest next start is sampled the cycle after done.
- Result and flags change only on completion (E1 special or E14 normal); they are stable in every other cycle.
- Flags are not sticky across operations: each completion overwrites all 4 bits.

Test Plan:
- 1.0/1.0: a=3C00, b=3C00 -> result=3C00, flags=0000, done exactly 14 edges after start, busy high 15 cycles.
- 6.0/2.0 and 1/3: 4600/4000 -> 4200. 3C00/4200 -> 3555 (truncated), flags=0000.
- Overflow/underflow:
  - 7BFF/1400 -> 7C00, flags=0010.
  - 0400/7800 -> 0000, flags=0001.
  - 8400/7800 -> 8000, flags=0001.
- Specials, each with done after 2 edges:
  - C000/0000 -> FC00, flags=0100.
  - 7E01/3C00 -> 7E00, flags=1000.
  - 0000/8000 -> 7E00, flags=1000.
  - 7C00/FC00 -> 7E00, flags=1000.
  - 3C00/7C00 -> 0000, flags=0000.
- Handshake:
  - start held high continuously: back-to-back ops 4600/4000 then 3C00/4200 complete with no lost or duplicated done.
  - start pulsed during DIV and DONE is ignored; result holds 4200 until the second done.
- Reset mid-op: assert reset during DIV (edge E6) -> busy, done, result, flags go to 0 immediately without waiting for a clock edge; no done afterward. A fresh 3C00/3C00 then completes normally.
